// File: rtl/irrigation_valve_driver_if.sv
// rtl/irrigation_valve_driver_if.sv - request inputs and valve drive outputs of the valve driver
interface irrigation_valve_driver_if;
    logic req_supply;
    logic req_sprinkler;
    logic req_dripper;
    logic error;
    logic high;
    logic alarm_clr;
    logic valve_supply;
    logic valve_sprinkler;
    logic valve_dripper;
    logic fill_alarm;
    logic busy;

    modport master (
        output req_supply, req_sprinkler, req_dripper, error, high, alarm_clr,
        input  valve_supply, valve_sprinkler, valve_dripper, fill_alarm, busy
    );

    modport slave (
        input  req_supply, req_sprinkler, req_dripper, error, high, alarm_clr,
        output valve_supply, valve_sprinkler, valve_dripper, fill_alarm, busy
    );
endinterface

// File: rtl/irrigation_valve_driver.sv
// rtl/irrigation_valve_driver.sv - timed valve drive stage with min-on, gap, exclusion and fill alarm
module irrigation_valve_driver #(
    parameter int TICK_DIV           = 1000,
    parameter int MIN_ON_TICKS       = 5,
    parameter int GAP_TICKS          = 3,
    parameter int FILL_TIMEOUT_TICKS = 20
) (
    input logic                      clk,
    input logic                      rst_n,
    irrigation_valve_driver_if.slave ctl
);

    localparam int RUN_MAX = (MIN_ON_TICKS > GAP_TICKS) ? MIN_ON_TICKS : GAP_TICKS;
    localparam int TICK_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int RUN_W   = (RUN_MAX > 0) ? $clog2(RUN_MAX + 1) : 1;
    localparam int FILL_W  = (FILL_TIMEOUT_TICKS > 0) ? $clog2(FILL_TIMEOUT_TICKS + 1) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [RUN_W-1:0]  RUN_LIMIT  = RUN_W'(RUN_MAX);
    localparam logic [RUN_W-1:0]  MIN_ON_LIM = RUN_W'(MIN_ON_TICKS);
    localparam logic [RUN_W-1:0]  GAP_LIM    = RUN_W'(GAP_TICKS);
    localparam logic [FILL_W-1:0] FILL_LIM   = FILL_W'(FILL_TIMEOUT_TICKS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPRINKLE,
        ST_DRIP,
        ST_GAP,
        ST_FAULT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [TICK_W-1:0]  tick_cnt;
    logic               tick;
    logic [RUN_W-1:0]   run_cnt;
    logic [RUN_W-1:0]   run_adv;
    logic [FILL_W-1:0]  fill_cnt;
    logic [FILL_W-1:0]  fill_adv;
    logic               timeout_hit;
    logic               supply_q;
    logic               supply_nxt;
    logic               alarm_q;
    logic               alarm_nxt;
    logic               sprinkler_q;
    logic               dripper_q;
    logic               busy_q;

    assign tick = (tick_cnt == TICK_LAST);

    // Free-running tick divider, restarts from zero on reset so no stale partial tick survives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Value run_cnt takes at this edge if the state holds; thresholds compare against it so
    // an interval ends on the very tick that completes it
    always_comb begin
        run_adv = run_cnt;
        if (tick && (run_cnt != RUN_LIMIT)) begin
            run_adv = run_cnt + RUN_W'(1);
        end
    end

    // Irrigation mode sequencing: error always wins, active mode is never preempted by the other
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ctl.error) begin
                    state_nxt = ST_FAULT;
                end else if (ctl.req_sprinkler) begin
                    state_nxt = ST_SPRINKLE;
                end else if (ctl.req_dripper) begin
                    state_nxt = ST_DRIP;
                end
            end
            ST_SPRINKLE: begin
                if (ctl.error) begin
                    state_nxt = ST_FAULT;
                end else if (!ctl.req_sprinkler && (run_adv >= MIN_ON_LIM)) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_DRIP: begin
                if (ctl.error) begin
                    state_nxt = ST_FAULT;
                end else if (!ctl.req_dripper && (run_adv >= MIN_ON_LIM)) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (ctl.error) begin
                    state_nxt = ST_FAULT;
                end else if (run_adv >= GAP_LIM) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (!ctl.error) begin
                    state_nxt = ST_GAP;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; the residence timer restarts on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            run_cnt <= '0;
        end else begin
            state   <= state_nxt;
            run_cnt <= (state_nxt != state) ? '0 : run_adv;
        end
    end

    // Irrigation drive outputs registered from the next state so they track the FSM with no decode glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sprinkler_q <= 1'b0;
            dripper_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sprinkler_q <= (state_nxt == ST_SPRINKLE);
            dripper_q   <= (state_nxt == ST_DRIP);
            busy_q      <= (state_nxt != ST_IDLE);
        end
    end

    // Fill supervision: a timeout only counts while high is still low, so a full tank beats the alarm
    always_comb begin
        fill_adv = fill_cnt;
        if (tick && (fill_cnt != FILL_LIM)) begin
            fill_adv = fill_cnt + FILL_W'(1);
        end
        timeout_hit = supply_q && !ctl.high && (fill_adv >= FILL_LIM);
        supply_nxt  = ctl.req_supply && !ctl.high && !ctl.error && !alarm_q && !timeout_hit;
        alarm_nxt   = timeout_hit || (alarm_q && !ctl.alarm_clr);
    end

    // Supply valve, latched alarm and the open-time counter, which only runs while the valve is open
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            supply_q <= 1'b0;
            alarm_q  <= 1'b0;
            fill_cnt <= '0;
        end else begin
            supply_q <= supply_nxt;
            alarm_q  <= alarm_nxt;
            fill_cnt <= supply_q ? fill_adv : '0;
        end
    end

    assign ctl.valve_supply    = supply_q;
    assign ctl.valve_sprinkler = sprinkler_q;
    assign ctl.valve_dripper   = dripper_q;
    assign ctl.fill_alarm      = alarm_q;
    assign ctl.busy            = busy_q;

endmodule
